if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC and drives the word-addressed instruction memory bank, which has a combinational read. Latches the returned instruction into the IF/ID pipeline register. Accepts stall requests from the hazard unit and branch/jump redirects from ID/EX.

---
 rtl/if_fetch_stage.sv | 121 ++++++++++++
 tb/tb_if_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, fills IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_memread,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;
    localparam logic [30:0] DEPTH_WORDS      = 31'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_d, instr_d, pc4_d;
    logic        valid_d, fault_d;
    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign imem_address = pc;
    assign pc_plus4     = pc + 32'd4;
    assign out_of_range = {1'b0, pc[31:2]} >= DEPTH_WORDS;

    // NOTE: every output of this block gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        instr_d = ifid_instr;
        pc4_d   = ifid_pc4;
        valid_d = ifid_valid;
        fault_d = fetch_fault;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc & ~32'd3;
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // hold everything
                end else if (out_of_range) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    instr_d = 32'h0;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = imem_readdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc           <= RESET_PC_ALIGNED;
            ifid_instr   <= 32'h0;
            ifid_pc4     <= 32'h0;
            ifid_valid   <= 1'b0;
            fetch_fault  <= 1'b0;
            imem_memread <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            ifid_instr   <= instr_d;
            ifid_pc4     <= pc4_d;
            ifid_valid   <= valid_d;
            fetch_fault  <= fault_d;
            imem_memread <= (state_d == RUN);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic in_run, flush_edge, stall_edge, fetch_edge;

    assign in_run     = (state_q == RUN);
    assign flush_edge = in_run && redirect_valid;
    assign stall_edge = in_run && !redirect_valid && stall;
    assign fetch_edge = in_run && !redirect_valid && !stall && !out_of_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (fetch_edge) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_edge) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_edge) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a full-depth and a 4-word instance share stimulus and
// are compared each cycle against a rule-level reference model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        b_memread, b_valid, b_fault;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc4, b_pc, b_pf, b_ps, b_pfl;
    logic        s_memread, s_valid, s_fault;
    logic [31:0] s_addr, s_rdata, s_instr, s_pc4, s_pc, s_pf, s_ps, s_pfl;

    logic [31:0] mem [64];

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        bit          started, halted, memread, valid, fault;
        logic [31:0] pc, instr, pc4, nf, ns, nfl;
    } model_t;

    model_t mb, ms;

    always #5 clk = ~clk;

    assign b_rdata = mem[b_addr[7:2]];
    assign s_rdata = mem[s_addr[7:2]];

    if_fetch_stage dut_big (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_memread(b_memread), .imem_address(b_addr),
        .imem_readdata(b_rdata), .ifid_instr(b_instr), .ifid_pc4(b_pc4),
        .ifid_valid(b_valid), .pc(b_pc), .fetch_fault(b_fault),
        .perf_fetch_cnt(b_pf), .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pfl)
    );

    if_fetch_stage #(.IMEM_DEPTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_memread(s_memread), .imem_address(s_addr),
        .imem_readdata(s_rdata), .ifid_instr(s_instr), .ifid_pc4(s_pc4),
        .ifid_valid(s_valid), .pc(s_pc), .fetch_fault(s_fault),
        .perf_fetch_cnt(s_pf), .perf_stall_cnt(s_ps), .perf_flush_cnt(s_pfl)
    );

    function automatic model_t model_reset();
        model_t m;
        m.started = 0; m.halted = 0; m.memread = 0; m.valid = 0; m.fault = 0;
        m.pc = 32'h0; m.instr = 32'h0; m.pc4 = 32'h0;
        m.nf = 32'h0; m.ns = 32'h0; m.nfl = 32'h0;
        return m;
    endfunction

    // One clock edge of the fetch rules: start-up edge, then redirect > stall > range > fetch.
    function automatic model_t step(model_t m, int depth);
        if (m.halted) return m;
        if (!m.started) begin
            m.started = 1; m.memread = 1;
        end else if (redirect_valid) begin
            m.pc = {redirect_pc[31:2], 2'b00};
            m.valid = 0; m.instr = 32'h0; m.pc4 = 32'h0;
            m.nfl = m.nfl + 1;
        end else if (stall) begin
            m.ns = m.ns + 1;
        end else if ((m.pc / 4) >= depth) begin
            m.halted = 1; m.memread = 0; m.fault = 1; m.valid = 0; m.instr = 32'h0;
        end else begin
            m.instr = mem[m.pc[7:2]];
            m.pc = m.pc + 4;
            m.pc4 = m.pc;
            m.valid = 1;
            m.nf = m.nf + 1;
        end
        return m;
    endfunction

    function automatic logic [98:0] pack(model_t m);
        return {m.pc, m.instr, m.pc4, m.valid, m.memread, m.fault};
    endfunction

    function automatic logic [95:0] perf_exp(model_t m);
`ifdef IF_PERF_CNT_EN
        return {m.nf, m.ns, m.nfl};
`else
        return 96'h0;
`endif
    endfunction

    function automatic logic [98:0] obs_b();
        return {b_pc, b_instr, b_pc4, b_valid, b_memread, b_fault};
    endfunction

    function automatic logic [98:0] obs_s();
        return {s_pc, s_instr, s_pc4, s_valid, s_memread, s_fault};
    endfunction

    task automatic cycle();
        if (rst_n) begin
            mb = step(mb, 2048);
            ms = step(ms, 4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mb = model_reset();
        ms = model_reset();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        mb = model_reset();
        ms = model_reset();
        #2;
        nvec++;
        if (obs_b() !== pack(mb)) begin
            nerr++; $display("FAIL reset_big: got %h want %h", obs_b(), pack(mb));
        end
        nvec++;
        if (obs_s() !== pack(ms)) begin
            nerr++; $display("FAIL reset_small: got %h want %h", obs_s(), pack(ms));
        end
        nvec++;
        if ({b_pf, b_ps, b_pfl} !== 96'h0) begin
            nerr++; $display("FAIL reset_perf: got %h want 0", {b_pf, b_ps, b_pfl});
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        do_reset();
        cycle();
        nvec++;
        if (b_valid !== 1'b0 || b_memread !== 1'b1 || b_pc !== 32'h0) begin
            nerr++; $display("FAIL seq_idle: got valid=%b rd=%b pc=%h want 0 1 0", b_valid, b_memread, b_pc);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            nvec++;
            if (b_instr !== mem[i] || b_pc4 !== 32'(4 * (i + 1)) || b_valid !== 1'b1) begin
                nerr++; $display("FAIL seq_fetch%0d: got %h/%h want %h/%h", i, b_instr, b_pc4, mem[i], 4 * (i + 1));
            end
        end
        nvec++;
        if (b_pc !== 32'd16 || obs_b() !== pack(mb)) begin
            nerr++; $display("FAIL seq_end: got %h want %h", obs_b(), pack(mb));
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            nvec++;
            if (b_pc !== 32'd8 || b_instr !== mem[1] || b_pc4 !== 32'd8) begin
                nerr++; $display("FAIL stall_hold%0d: got pc=%h instr=%h pc4=%h want 8 %h 8", i, b_pc, b_instr, b_pc4, mem[1]);
            end
        end
        stall = 1'b0;
        cycle();
        nvec++;
        if (b_instr !== mem[2] || b_pc !== 32'd12) begin
            nerr++; $display("FAIL stall_release: got %h pc=%h want %h pc=c", b_instr, b_pc, mem[2]);
        end
        nvec++;
        if ({b_pf, b_ps, b_pfl} !== perf_exp(mb)) begin
            nerr++; $display("FAIL stall_perf: got %h want %h", {b_pf, b_ps, b_pfl}, perf_exp(mb));
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h42; stall = 1'b1;
        cycle();
        redirect_valid = 1'b0; stall = 1'b0;
        nvec++;
        if (b_pc !== 32'h40 || b_valid !== 1'b0 || b_instr !== 32'h0) begin
            nerr++; $display("FAIL redirect_squash: got pc=%h v=%b i=%h want 40 0 0", b_pc, b_valid, b_instr);
        end
        cycle();
        nvec++;
        if (b_instr !== mem[16] || b_pc4 !== 32'h44 || b_valid !== 1'b1) begin
            nerr++; $display("FAIL redirect_fetch: got %h/%h want %h/44", b_instr, b_pc4, mem[16]);
        end
        nvec++;
        if ({b_pf, b_ps, b_pfl} !== perf_exp(mb)) begin
            nerr++; $display("FAIL redirect_perf: got %h want %h", {b_pf, b_ps, b_pfl}, perf_exp(mb));
        end
    endtask

    task automatic test_range_halt();
        do_reset();
        repeat (5) cycle();
        nvec++;
        if (s_pc !== 32'd16 || s_instr !== mem[3] || s_fault !== 1'b0) begin
            nerr++; $display("FAIL range_pre: got pc=%h i=%h f=%b want 10 %h 0", s_pc, s_instr, s_fault, mem[3]);
        end
        cycle();
        nvec++;
        if (s_fault !== 1'b1 || s_memread !== 1'b0 || s_valid !== 1'b0 || s_pc !== 32'd16) begin
            nerr++; $display("FAIL range_halt: got f=%b rd=%b v=%b pc=%h want 1 0 0 10", s_fault, s_memread, s_valid, s_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        nvec++;
        if (obs_s() !== pack(ms) || s_pc !== 32'd16 || s_fault !== 1'b1) begin
            nerr++; $display("FAIL range_absorb: got %h want %h", obs_s(), pack(ms));
        end
    endtask

    task automatic test_stall_out_of_range();
        do_reset();
        repeat (5) cycle();
        stall = 1'b1;
        repeat (4) cycle();
        nvec++;
        if (s_fault !== 1'b0 || s_memread !== 1'b1 || s_pc !== 32'd16) begin
            nerr++; $display("FAIL oor_stall: got f=%b rd=%b pc=%h want 0 1 10", s_fault, s_memread, s_pc);
        end
        stall = 1'b0;
        cycle();
        nvec++;
        if (s_fault !== 1'b1 || obs_s() !== pack(ms)) begin
            nerr++; $display("FAIL oor_release: got %h want %h", obs_s(), pack(ms));
        end
    endtask

    task automatic test_range_redirect();
        do_reset();
        repeat (5) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        nvec++;
        if (s_fault !== 1'b0 || s_pc !== 32'h0 || s_valid !== 1'b0) begin
            nerr++; $display("FAIL rr_redirect: got f=%b pc=%h v=%b want 0 0 0", s_fault, s_pc, s_valid);
        end
        cycle();
        nvec++;
        if (s_instr !== mem[0] || s_valid !== 1'b1 || s_pc !== 32'd4) begin
            nerr++; $display("FAIL rr_continue: got i=%h v=%b pc=%h want %h 1 4", s_instr, s_valid, s_pc, mem[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (9) cycle();
        nvec++;
        if (b_pc !== 32'h20) begin
            nerr++; $display("FAIL arst_pre: got pc=%h want 20", b_pc);
        end
        #3;
        rst_n = 1'b0;
        mb = model_reset();
        ms = model_reset();
        #1;
        nvec++;
        if (obs_b() !== pack(mb) || b_pc !== 32'h0 || {b_pf, b_ps, b_pfl} !== 96'h0) begin
            nerr++; $display("FAIL arst_clear: got %h want %h", obs_b(), pack(mb));
        end
        #2;
        rst_n = 1'b1;
        cycle();
        nvec++;
        if (b_valid !== 1'b0 || b_memread !== 1'b1 || b_pc !== 32'h0) begin
            nerr++; $display("FAIL arst_idle: got v=%b rd=%b pc=%h want 0 1 0", b_valid, b_memread, b_pc);
        end
        cycle();
        nvec++;
        if (b_instr !== mem[0] || b_pc4 !== 32'd4) begin
            nerr++; $display("FAIL arst_resume: got %h/%h want %h/4", b_instr, b_pc4, mem[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                stall          = ($urandom_range(0, 3) == 0);
                redirect_valid = ($urandom_range(0, 5) == 0);
                redirect_pc    = 32'($urandom_range(0, 255));
                cycle();
                nvec++;
                if (obs_b() !== pack(mb) || {b_pf, b_ps, b_pfl} !== perf_exp(mb)) begin
                    nerr++; $display("FAIL rand_big b%0d c%0d: got %h %h want %h %h", blk, c,
                                     obs_b(), {b_pf, b_ps, b_pfl}, pack(mb), perf_exp(mb));
                end
                nvec++;
                if (obs_s() !== pack(ms) || {s_pf, s_ps, s_pfl} !== perf_exp(ms)) begin
                    nerr++; $display("FAIL rand_small b%0d c%0d: got %h %h want %h %h", blk, c,
                                     obs_s(), {s_pf, s_ps, s_pfl}, pack(ms), perf_exp(ms));
                end
            end
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_range_halt();
        test_stall_out_of_range();
        test_range_redirect();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
